// File: rtl/sample_playback_ctrl.sv
// Flash-backed audio sample player: fetches 32-bit words (two 16-bit samples)
// and emits one sample per programmable period, forward or reverse, with wrap.
module sample_playback_ctrl #(
   parameter int unsigned       ADDR_W     = 23,
   parameter logic [ADDR_W-1:0] START_ADDR = '0,
   parameter logic [ADDR_W-1:0] END_ADDR   = 23'h7FFFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       divisor,
   input  logic              play,
   input  logic              pause,
   input  logic              reverse,
   input  logic              restart,
   output logic              flash_read,
   output logic [ADDR_W-1:0] flash_addr,
   input  logic              flash_waitrequest,
   input  logic              flash_readdatavalid,
   input  logic [31:0]       flash_readdata,
   output logic [15:0]       sample_out,
   output logic              sample_valid,
   output logic [2:0]        o_dbg_state
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_FETCH     = 3'd1;
   localparam logic [2:0] S_WAIT_DATA = 3'd2;
   localparam logic [2:0] S_WAIT_T1   = 3'd3;
   localparam logic [2:0] S_WAIT_T2   = 3'd4;

   // Flash handshake: a read is accepted on a cycle with flash_read=1 and
   // flash_waitrequest=0; flash_addr is held stable until then. Exactly one
   // read is ever outstanding; its data arrives on flash_readdatavalid.

   logic [2:0]        r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_pend_addr;
   logic [31:0]       r_cnt;
   logic [31:0]       r_period;
   logic [31:0]       r_word;
   logic              r_rev;
   logic              r_discard;
   logic              r_jump;
   logic              r_valid;
   logic [15:0]       r_sample;

   logic [31:0]       w_div_eff;
   logic [31:0]       w_period;
   logic              w_in_tone;
   logic              w_run;
   logic              w_tick;
   logic [ADDR_W-1:0] w_restart_addr;
   logic [ADDR_W-1:0] w_next_addr;

   assign w_div_eff      = (divisor < 32'd2) ? 32'd2 : divisor;
   // The period is captured on the first counting cycle after a reload.
   assign w_period       = (r_cnt == 32'd0) ? w_div_eff : r_period;
   assign w_in_tone      = (r_state == S_WAIT_T1) || (r_state == S_WAIT_T2);
   assign w_run          = w_in_tone && !pause && play && !restart;
   assign w_tick         = w_run && (r_cnt == w_period - 32'd1);
   assign w_restart_addr = reverse ? END_ADDR : START_ADDR;

   always_comb begin
      w_next_addr = r_addr;
      if (r_rev) w_next_addr = (r_addr == START_ADDR) ? END_ADDR : r_addr - ADDR_W'(1);
      else       w_next_addr = (r_addr == END_ADDR) ? START_ADDR : r_addr + ADDR_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= 32'd0;
         r_period <= 32'd2;
      end else if (restart) begin
         r_cnt <= 32'd0;
      end else if (w_run) begin
         if (r_cnt == 32'd0) r_period <= w_div_eff;
         r_cnt <= w_tick ? 32'd0 : r_cnt + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_addr      <= START_ADDR;
         r_pend_addr <= START_ADDR;
         r_word      <= 32'd0;
         r_rev       <= 1'b0;
         r_discard   <= 1'b0;
         r_jump      <= 1'b0;
         r_valid     <= 1'b0;
         r_sample    <= 16'd0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (restart) r_addr <= w_restart_addr;
               if (play) r_state <= S_FETCH;
            end
            S_FETCH: begin
               if (restart) begin
                  r_jump      <= 1'b1;
                  r_pend_addr <= w_restart_addr;
               end
               if (restart || !play) r_discard <= 1'b1;
               if (!flash_waitrequest) r_state <= S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
               if (restart) begin
                  r_jump      <= 1'b1;
                  r_pend_addr <= w_restart_addr;
               end
               if (restart || !play) r_discard <= 1'b1;
               if (flash_readdatavalid) begin
                  if (r_discard || restart || !play) begin
                     // Word dropped; a pending restart moves the address now.
                     r_discard <= 1'b0;
                     r_jump    <= 1'b0;
                     if (restart)     r_addr <= w_restart_addr;
                     else if (r_jump) r_addr <= r_pend_addr;
                     r_state <= play ? S_FETCH : S_IDLE;
                  end else begin
                     r_word  <= flash_readdata;
                     r_rev   <= reverse;
                     r_state <= S_WAIT_T1;
                  end
               end
            end
            S_WAIT_T1: begin
               if (restart) begin
                  r_addr  <= w_restart_addr;
                  r_state <= play ? S_FETCH : S_IDLE;
               end else if (!play) begin
                  r_state <= S_IDLE;
               end else if (w_tick) begin
                  r_sample <= r_rev ? r_word[31:16] : r_word[15:0];
                  r_valid  <= 1'b1;
                  r_state  <= S_WAIT_T2;
               end
            end
            S_WAIT_T2: begin
               if (restart) begin
                  r_addr  <= w_restart_addr;
                  r_state <= play ? S_FETCH : S_IDLE;
               end else if (!play) begin
                  r_state <= S_IDLE;
               end else if (w_tick) begin
                  r_sample <= r_rev ? r_word[15:0] : r_word[31:16];
                  r_valid  <= 1'b1;
                  r_addr   <= w_next_addr;
                  r_state  <= S_FETCH;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign flash_read   = (r_state == S_FETCH);
   assign flash_addr   = r_addr;
   assign sample_out   = r_sample;
   assign sample_valid = r_valid;
   assign o_dbg_state  = r_state;

endmodule
